// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_pkg
// Purpose  : Shared state encoding and sizing helper for the serial subtractor.
// Revision : 1.0
// ============================================================================
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width; never below 1 so the counter always exists.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Start/done operand and result bundle for the serial subtractor.
// Revision : 1.0
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             borrow_out;
    logic             zero;

    modport master (
        output start, a, b,
        input  ready, done, difference, borrow_out, zero
    );

    modport slave (
        input  start, a, b,
        output ready, done, difference, borrow_out, zero
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_full_sub.sv
`default_nettype none
// ============================================================================
// Module   : half_subtractor / full_subtractor
// Purpose  : One-bit subtract cell built from two half subtractors and an OR.
// Revision : 1.0
// ============================================================================
module half_subtractor (
    input  wire logic a,
    input  wire logic b,
    output logic      diff,
    output logic      borrow
);
    assign diff   = a ^ b;
    assign borrow = ~a & b;
endmodule

module full_subtractor (
    input  wire logic a,
    input  wire logic b,
    input  wire logic bin,
    output logic      diff,
    output logic      bout
);
    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs_ab (
        .a      (a),
        .b      (b),
        .diff   (d1),
        .borrow (b1)
    );

    half_subtractor u_hs_bin (
        .a      (d1),
        .b      (bin),
        .diff   (diff),
        .borrow (b2)
    );

    assign bout = b1 | b2;
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial LSB-first a - b with one borrow flop and start/done.
// Revision : 1.0
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);

    localparam int              CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   C_ONE  = CW'(1);

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic [WIDTH-1:0] res_q,        res_d;
    logic             borrow_q,     borrow_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic [WIDTH-1:0] difference_q, difference_d;
    logic             borrow_out_q, borrow_out_d;
    logic             zero_q,       zero_d;

    logic             bit_diff;
    logic             bit_bout;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .diff (bit_diff),
        .bout (bit_bout)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {bit_diff, res_q[WIDTH-1:1]};

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        difference_d = difference_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                res_d    = res_next;
                borrow_d = bit_bout;
                cnt_d    = cnt_q + C_ONE;
                if (cnt_q == C_LAST) begin
                    difference_d = res_next;
                    borrow_out_d = bit_bout;
                    zero_d       = (res_next == '0);
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            difference_q <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            difference_q <= difference_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
        end
    end

    assign bus.ready      = (state_q == IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.difference = difference_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.zero       = zero_q;

endmodule
`default_nettype wire
